// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives data-memory loads/stores over a req/ack handshake,
// stalls upstream while an access is outstanding and registers the MEM/WB boundary.

module mem_lane #(
  parameter int VEC_W = 8
) (
  input  logic             sel,
  input  logic             is_byte,
  input  logic [VEC_W-1:0] byte0,
  input  logic [VEC_W-1:0] lane_byte,
  output logic             be,
  output logic [VEC_W-1:0] wdata
);
  // Byte stores replicate the low store byte into every lane and enable only one.
  assign be    = is_byte ? sel : 1'b1;
  assign wdata = is_byte ? byte0 : lane_byte;
endmodule

module mem_access_stage #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       EXE_MEM_Result,
  input  logic [63:0]       EXE_MEM_Treg,
  input  logic [4:0]        EXE_MEM_DstReg,
  input  logic [4:0]        EXE_MEM_FP_DstReg,
  input  logic              EXE_MEM_MemRead,
  input  logic              EXE_MEM_MemWrite,
  input  logic              EXE_MEM_MemtoReg,
  input  logic              EXE_MEM_RegWrite,
  input  logic              EXE_MEM_Byte,
  input  logic              EXE_MEM_JmpandLink,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [63:0]       dmem_wdata,
  output logic [7:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [63:0]       dmem_rdata,
  output logic              mem_stall,
  output logic              mem_err,
  output logic [63:0]       MEM_WB_Result,
  output logic [63:0]       MEM_WB_ReadData,
  output logic [4:0]        MEM_WB_DstReg,
  output logic [4:0]        MEM_WB_FP_DstReg,
  output logic              MEM_WB_MemtoReg,
  output logic              MEM_WB_RegWrite,
  output logic              MEM_WB_JmpandLink
);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 8;
  localparam int CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       wdata;
    logic [7:0]        be;
    logic              is_byte;
    logic [2:0]        lane;
  } dreq_t;

  state_t     state_q, state_d;
  dreq_t      req_d, req_q;
  logic       req_vld_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0] hold_q;
  logic       abort_q;
  logic       op, start, ack_hit, tmo_hit, tmo;

  logic [NUM_LANES-1:0][VEC_W-1:0] treg_b, wdata_b, rdata_b;
  logic [NUM_LANES-1:0]            be_b;
  logic [VEC_W-1:0]                rbyte;
  logic [63:0]                     load_fmt;

  assign op      = EXE_MEM_MemRead | EXE_MEM_MemWrite;
  assign treg_b  = EXE_MEM_Treg;
  assign rdata_b = dmem_rdata;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mem_lane #(.VEC_W(VEC_W)) u_lane (
      .sel      (EXE_MEM_Result[2:0] == 3'(i)),
      .is_byte  (EXE_MEM_Byte),
      .byte0    (EXE_MEM_Treg[7:0]),
      .lane_byte(treg_b[i]),
      .be       (be_b[i]),
      .wdata    (wdata_b[i])
    );
  end

  always_comb begin
    req_d         = '0;
    req_d.we      = EXE_MEM_MemWrite;
    req_d.addr    = {EXE_MEM_Result[ADDR_W-1:3], 3'b000};
    req_d.wdata   = wdata_b;
    req_d.be      = be_b;
    req_d.is_byte = EXE_MEM_Byte;
    req_d.lane    = EXE_MEM_Result[2:0];
  end

  // Lane comes from the captured request so formatting never depends on upstream holding.
  assign rbyte    = rdata_b[req_q.lane];
  assign load_fmt = req_q.is_byte ? {{56{rbyte[7]}}, rbyte} : dmem_rdata;
  assign tmo      = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  assign dmem_req   = req_vld_q;
  assign dmem_we    = req_q.we;
  assign dmem_addr  = req_q.addr;
  assign dmem_wdata = req_q.wdata;
  assign dmem_be    = req_q.be;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    start     = 1'b0;
    ack_hit   = 1'b0;
    tmo_hit   = 1'b0;
    case (state_q)
      IDLE: if (op) begin
        mem_stall = 1'b1;
        start     = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        mem_stall = 1'b1;
        if (dmem_ack) begin
          ack_hit = 1'b1;
          state_d = DONE;
        end else if (tmo) begin
          tmo_hit = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q             <= '0;
      req_vld_q         <= 1'b0;
      cnt_q             <= '0;
      hold_q            <= '0;
      abort_q           <= 1'b0;
      mem_err           <= 1'b0;
      MEM_WB_Result     <= '0;
      MEM_WB_ReadData   <= '0;
      MEM_WB_DstReg     <= '0;
      MEM_WB_FP_DstReg  <= '0;
      MEM_WB_MemtoReg   <= 1'b0;
      MEM_WB_RegWrite   <= 1'b0;
      MEM_WB_JmpandLink <= 1'b0;
    end else begin
      mem_err <= tmo_hit;
      if (start) begin
        req_q     <= req_d;
        req_vld_q <= 1'b1;
        cnt_q     <= '0;
      end
      if (state_q == ACCESS) begin
        if (ack_hit || tmo_hit) req_vld_q <= 1'b0;
        else                    cnt_q     <= cnt_q + 1'b1;
      end
      if (ack_hit && !req_q.we) hold_q  <= load_fmt;
      if (tmo_hit)              abort_q <= 1'b1;

      MEM_WB_Result    <= EXE_MEM_Result;
      MEM_WB_DstReg    <= EXE_MEM_DstReg;
      MEM_WB_FP_DstReg <= EXE_MEM_FP_DstReg;
      if (mem_stall) begin
        MEM_WB_RegWrite   <= 1'b0;
        MEM_WB_MemtoReg   <= 1'b0;
        MEM_WB_JmpandLink <= 1'b0;
      end else begin
        MEM_WB_RegWrite   <= EXE_MEM_RegWrite & ~((state_q == DONE) & abort_q);
        MEM_WB_MemtoReg   <= EXE_MEM_MemtoReg;
        MEM_WB_JmpandLink <= EXE_MEM_JmpandLink;
      end
      if (state_q == DONE) begin
        MEM_WB_ReadData <= hold_q;
        abort_q         <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench: main instance (default timeout) plus a TIMEOUT=3 instance for the abort path.

module tb_mem_access_stage;
  logic clk, rst_n;
  logic [63:0] res, treg;
  logic [4:0]  dst, fpdst;
  logic rd, wr, m2r, rw, byt, jal;
  logic t_rd, t_wr;
  logic ack, t_ack;
  logic [63:0] rdata;

  logic        req, we, stall, err, wb_m2r, wb_rw, wb_jal;
  logic [31:0] addr;
  logic [63:0] wdata, wb_res, wb_rd;
  logic [7:0]  be;
  logic [4:0]  wb_dst, wb_fpdst;

  logic        t_req, t_we, t_stall, t_err, t_wb_m2r, t_wb_rw, t_wb_jal;
  logic [31:0] t_addr;
  logic [63:0] t_wdata, t_wb_res, t_wb_rd;
  logic [7:0]  t_be;
  logic [4:0]  t_wb_dst, t_wb_fpdst;

  int n_checks = 0;
  int n_err    = 0;

  mem_access_stage u_dut (
    .clk(clk), .rst_n(rst_n),
    .EXE_MEM_Result(res), .EXE_MEM_Treg(treg), .EXE_MEM_DstReg(dst), .EXE_MEM_FP_DstReg(fpdst),
    .EXE_MEM_MemRead(rd), .EXE_MEM_MemWrite(wr), .EXE_MEM_MemtoReg(m2r), .EXE_MEM_RegWrite(rw),
    .EXE_MEM_Byte(byt), .EXE_MEM_JmpandLink(jal),
    .dmem_req(req), .dmem_we(we), .dmem_addr(addr), .dmem_wdata(wdata), .dmem_be(be),
    .dmem_ack(ack), .dmem_rdata(rdata), .mem_stall(stall), .mem_err(err),
    .MEM_WB_Result(wb_res), .MEM_WB_ReadData(wb_rd), .MEM_WB_DstReg(wb_dst),
    .MEM_WB_FP_DstReg(wb_fpdst), .MEM_WB_MemtoReg(wb_m2r), .MEM_WB_RegWrite(wb_rw),
    .MEM_WB_JmpandLink(wb_jal)
  );

  mem_access_stage #(.TIMEOUT(3)) u_tmo (
    .clk(clk), .rst_n(rst_n),
    .EXE_MEM_Result(res), .EXE_MEM_Treg(treg), .EXE_MEM_DstReg(dst), .EXE_MEM_FP_DstReg(fpdst),
    .EXE_MEM_MemRead(t_rd), .EXE_MEM_MemWrite(t_wr), .EXE_MEM_MemtoReg(m2r), .EXE_MEM_RegWrite(rw),
    .EXE_MEM_Byte(byt), .EXE_MEM_JmpandLink(jal),
    .dmem_req(t_req), .dmem_we(t_we), .dmem_addr(t_addr), .dmem_wdata(t_wdata), .dmem_be(t_be),
    .dmem_ack(t_ack), .dmem_rdata(rdata), .mem_stall(t_stall), .mem_err(t_err),
    .MEM_WB_Result(t_wb_res), .MEM_WB_ReadData(t_wb_rd), .MEM_WB_DstReg(t_wb_dst),
    .MEM_WB_FP_DstReg(t_wb_fpdst), .MEM_WB_MemtoReg(t_wb_m2r), .MEM_WB_RegWrite(t_wb_rw),
    .MEM_WB_JmpandLink(t_wb_jal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [63:0] r, input logic [4:0] d, input logic r_, input logic w_,
                        input logic m_, input logic rw_, input logic b_);
    res = r; dst = d; rd = r_; wr = w_; m2r = m_; rw = rw_; byt = b_;
  endtask

  initial begin
    rst_n = 1'b0; res = '0; treg = '0; dst = '0; fpdst = '0;
    rd = 0; wr = 0; m2r = 0; rw = 0; byt = 0; jal = 0;
    t_rd = 0; t_wr = 0; ack = 0; t_ack = 0; rdata = '0;
    #1;
    chk("rst_req", req, 0);
    chk("rst_wb_res", wb_res, 0);
    chk("rst_err", err, 0);
    chk("rst_be", be, 0);
    #11 rst_n = 1'b1;
    tick();

    // ALU passthrough
    set_op(64'h1234, 5'd5, 0, 0, 0, 1, 0);
    fpdst = 5'd3;
    #1 chk("alu_stall", stall, 0);
    tick();
    chk("alu_res", wb_res, 64'h1234);
    chk("alu_dst", wb_dst, 5);
    chk("alu_fpdst", wb_fpdst, 3);
    chk("alu_rw", wb_rw, 1);
    chk("alu_rd_hold", wb_rd, 0);

    // 64-bit load, immediate ack
    set_op(64'h40, 5'd7, 1, 0, 1, 1, 0);
    #1 chk("ld_stall0", stall, 1);
    tick();
    chk("ld_req", req, 1);
    chk("ld_we", we, 0);
    chk("ld_addr", addr, 32'h40);
    chk("ld_be", be, 8'hFF);
    chk("ld_bubble1", wb_rw, 0);
    chk("ld_stall1", stall, 1);
    ack = 1; rdata = 64'hDEADBEEF_CAFEF00D;
    tick();
    ack = 0; rdata = '0;
    chk("ld_req_drop", req, 0);
    chk("ld_stall2", stall, 0);
    chk("ld_bubble2", wb_rw, 0);
    tick();
    chk("ld_data", wb_rd, 64'hDEADBEEF_CAFEF00D);
    chk("ld_m2r", wb_m2r, 1);
    chk("ld_rw", wb_rw, 1);
    chk("ld_dst", wb_dst, 7);

    // Byte load from lane 3
    set_op(64'h43, 5'd8, 1, 0, 1, 1, 1);
    tick();
    chk("bld_addr", addr, 32'h40);
    chk("bld_be", be, 8'h08);
    ack = 1; rdata = 64'h00000000_9C000000;
    tick();
    ack = 0; rdata = '0;
    tick();
    chk("bld_data", wb_rd, 64'hFFFFFFFF_FFFFFF9C);

    // Byte store with both MemRead and MemWrite high: treated as write
    set_op(64'h45, 5'd0, 1, 1, 0, 0, 1);
    treg = 64'h01234567_89AB_CDA5;
    tick();
    chk("bst_we", we, 1);
    chk("bst_be", be, 8'h20);
    chk("bst_wdata", wdata, 64'hA5A5A5A5_A5A5A5A5);
    chk("bst_addr", addr, 32'h40);
    ack = 1; rdata = 64'h11111111_11111111;
    tick();
    ack = 0; rdata = '0;
    tick();
    chk("bst_no_capture", wb_rd, 64'hFFFFFFFF_FFFFFF9C);
    chk("bst_rw", wb_rw, 0);

    // Delayed ack: four ACCESS cycles, five stall cycles total
    set_op(64'h88, 5'd9, 1, 0, 1, 1, 0);
    #1 chk("dly_stall0", stall, 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("dly_req%0d", i), req, 1);
      chk($sformatf("dly_addr%0d", i), addr, 32'h88);
      chk($sformatf("dly_stall%0d", i), stall, 1);
      if (i == 4) begin ack = 1; rdata = 64'h11223344_55667788; end
    end
    tick();
    ack = 0; rdata = '0;
    chk("dly_stall_end", stall, 0);
    chk("dly_req_drop", req, 0);
    tick();
    chk("dly_data", wb_rd, 64'h11223344_55667788);

    // Timeout on the TIMEOUT=3 instance
    set_op(64'h50, 5'd10, 0, 0, 1, 1, 0);
    t_rd = 1;
    #1 chk("tmo_stall0", t_stall, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("tmo_req%0d", i), t_req, 1);
      chk($sformatf("tmo_err%0d", i), t_err, 0);
    end
    tick();
    chk("tmo_req_drop", t_req, 0);
    chk("tmo_err_pulse", t_err, 1);
    chk("tmo_stall_done", t_stall, 0);
    tick();
    t_rd = 0;
    chk("tmo_err_clear", t_err, 0);
    chk("tmo_rw_killed", t_wb_rw, 0);
    chk("tmo_m2r", t_wb_m2r, 1);
    set_op(64'h77, 5'd11, 0, 0, 0, 1, 0);
    #1 chk("tmo_resume_stall", t_stall, 0);
    tick();
    chk("tmo_resume_rw", t_wb_rw, 1);
    chk("tmo_resume_res", t_wb_res, 64'h77);

    // Reset in the middle of an access
    set_op(64'h60, 5'd12, 1, 0, 1, 1, 0);
    tick();
    chk("mrst_req_pre", req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_req", req, 0);
    chk("mrst_wb_res", wb_res, 0);
    chk("mrst_wb_dst", wb_dst, 0);
    chk("mrst_wb_rd", wb_rd, 0);
    chk("mrst_wb_m2r", wb_m2r, 0);
    set_op(64'h99, 5'd13, 0, 0, 0, 1, 0);
    #1 rst_n = 1'b1;
    tick();
    chk("mrst_idle_res", wb_res, 64'h99);
    chk("mrst_idle_rw", wb_rw, 1);
    chk("mrst_idle_stall", stall, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
